sync_fifo: RTL and testbench

Single-clock, parametrised FIFO with write/read acknowledge, programmable almost-full/almost-empty thresholds, occupancy count and overflow/underflow error pulses. It is the next-generation buffer for same-domain producer/consumer paths in the design. It keeps the `wfull`/`rempty`/`wack`/`rack` signalling used elsewhere in the design, so consumers of those flags need no changes.

---
 rtl/sync_fifo.sv | 155 +++++++++++++++
 tb/tb_sync_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock parametrised FIFO with write/read acknowledge,
//            programmable almost-full/almost-empty thresholds, occupancy
//            count and single-cycle overflow/underflow pulses.
// Ports    :
//   clk          in   1         rising-edge clock for all logic
//   rst_n        in   1         synchronous active-low reset
//   wdata        in   DATASIZE  write data
//   wen          in   1         write request
//   ren          in   1         read request
//   rdata        out  DATASIZE  registered read data
//   wfull        out  1         FIFO full
//   rempty       out  1         FIFO empty
//   wack         out  1         previous cycle's write was accepted
//   rack         out  1         rdata holds data of previous accepted read
//   almost_full  out  1         count >= AFULL_THRESH
//   almost_empty out  1         count <= AEMPTY_THRESH
//   count        out  ADDRSIZE+1 current occupancy, 0..DEPTH
//   overflow     out  1         previous cycle's write was rejected
//   underflow    out  1         previous cycle's read was rejected
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DATASIZE      = 8,
  parameter int ADDRSIZE      = 4,
  parameter int AFULL_THRESH  = (2 ** ADDRSIZE) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                wen,
  input  logic                ren,
  output logic [DATASIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty,
  output logic                wack,
  output logic                rack,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam int DEPTH = 2 ** ADDRSIZE;
  localparam int PW    = ADDRSIZE + 1;

  // Thresholds brought to the counter width so all comparisons are
  // width-matched.
  localparam logic [ADDRSIZE:0] DEPTH_LVL  = PW'(DEPTH);
  localparam logic [ADDRSIZE:0] AFULL_LVL  = PW'(AFULL_THRESH);
  localparam logic [ADDRSIZE:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);

  // Elaboration-time parameter legality check.
  generate
    if (!((AEMPTY_THRESH >= 0) && (AEMPTY_THRESH < AFULL_THRESH) &&
          (AFULL_THRESH <= DEPTH))) begin : g_param_check
      $fatal(1, "sync_fifo: require 0 <= AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Storage and pointers. The pointer MSB is a wrap bit: equal low bits with
  // differing MSBs means full, fully equal pointers mean empty.
  // --------------------------------------------------------------------------
  logic [DATASIZE-1:0] mem [DEPTH];
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE:0]   rptr;

  logic                wr_acc;
  logic                rd_acc;
  logic [ADDRSIZE:0]   count_next;

  // Acceptance uses only the registered flags, so there is no path from
  // wen/ren through the flag logic back to any output in the same cycle.
  always_comb begin
    wr_acc     = wen && !wfull;
    rd_acc     = ren && !rempty;
    count_next = count + {{ADDRSIZE{1'b0}}, wr_acc} - {{ADDRSIZE{1'b0}}, rd_acc};
  end

  // Array contents are deliberately left out of reset; only the pointers
  // decide what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wptr[ADDRSIZE-1:0]] <= wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Control, status and read data
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      rdata        <= '0;
      wfull        <= 1'b0;
      rempty       <= 1'b1;
      almost_full  <= (AFULL_THRESH == 0);
      almost_empty <= 1'b1;
      wack         <= 1'b0;
      rack         <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_acc) begin
        rptr  <= rptr + 1'b1;
        rdata <= mem[rptr[ADDRSIZE-1:0]];
      end

      count        <= count_next;
      wfull        <= (count_next == DEPTH_LVL);
      rempty       <= (count_next == '0);
      almost_full  <= (count_next >= AFULL_LVL);
      almost_empty <= (count_next <= AEMPTY_LVL);

      wack         <= wr_acc;
      rack         <= rd_acc;
      overflow     <= wen && wfull;
      underflow    <= ren && rempty;
    end
  end

  // --------------------------------------------------------------------------
  // Consistency between the pointer view and the counter view of occupancy.
  // Ignored by synthesis; fires in simulation if the two ever disagree.
  // --------------------------------------------------------------------------
  logic [ADDRSIZE:0] ptr_diff;
  logic              ptr_full;
  logic              ptr_empty;

  always_comb begin
    ptr_diff  = wptr - rptr;
    ptr_full  = (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]) &&
                (wptr[ADDRSIZE] != rptr[ADDRSIZE]);
    ptr_empty = (wptr == rptr);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (ptr_diff == count && ptr_full == wfull && ptr_empty == rempty)
        else $error("sync_fifo: pointer/count disagreement");
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Purpose  : Self-checking bench for sync_fifo (DATASIZE=8, ADDRSIZE=4,
//            AFULL=14, AEMPTY=2). Read data expectations go through a
//            scoreboard queue consumed by a monitor on rack; status outputs
//            are compared directly against hand-derived values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wdata;
  logic       wen;
  logic       ren;
  logic [7:0] rdata;
  logic       wfull, rempty, wack, rack;
  logic       almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int total = 0;
  int bad   = 0;

  logic [7:0] model[$];   // expected FIFO contents
  logic [7:0] sb[$];      // expected rdata, one per accepted read

  sync_fifo #(
    .DATASIZE(8), .ADDRSIZE(4), .AFULL_THRESH(14), .AEMPTY_THRESH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wdata(wdata), .wen(wen), .ren(ren),
    .rdata(rdata), .wfull(wfull), .rempty(rempty), .wack(wack), .rack(rack),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rack must match the oldest expected read word.
  always @(posedge clk) begin
    #1;
    if (rack === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rack_unexpected: got rack=1 rdata=0x%0h expected no read", rdata);
      end else begin
        chk("rdata", {24'd0, rdata}, {24'd0, sb.pop_front()});
      end
    end
  end

  // One clock: drive at negedge, sample 1 time unit after the rising edge.
  task automatic cycle(input logic w, input logic r, input logic [7:0] d);
    bit wa, ra;
    @(negedge clk);
    wen   = w;
    ren   = r;
    wdata = d;
    if (rst_n) begin
      wa = w && (model.size() < 16);
      ra = r && (model.size() > 0);
      if (ra) sb.push_back(model.pop_front());
      if (wa) model.push_back(d);
    end
    @(posedge clk);
    #1;
  endtask

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  int wtog, rtog;
  logic wmsb, rmsb;

  initial begin
    rst_n = 1'b0; wen = 1'b1; ren = 1'b1; wdata = 8'h5A;

    // ---------------- Reset with wen/ren held high ----------------
    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_rempty", rempty, 1);
    chk("rst_wfull", wfull, 0);
    chk("rst_count", count, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_afull", almost_full, 0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_wack", wack, 0);
    chk("rst_rack", rack, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    @(negedge clk);
    rst_n = 1'b1; wen = 1'b0; ren = 1'b0;
    cycle(0, 0, 8'h00);

    // ---------------- Fill and overflow ----------------
    for (int i = 0; i < 16; i++) begin
      cycle(1, 0, 8'(i));
      chk("fill_count", count, i + 1);
      chk("fill_wack", wack, 1);
      chk("fill_afull", almost_full, (i + 1) >= 14);
      chk("fill_wfull", wfull, i == 15);
    end
    cycle(1, 0, 8'hAA);
    chk("ovf_pulse", overflow, 1);
    chk("ovf_wack", wack, 0);
    chk("ovf_count", count, 16);
    cycle(0, 0, 8'h00);
    chk("ovf_single", overflow, 0);

    // ---------------- Drain and underflow ----------------
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, 8'h00);
      chk("drain_rack", rack, 1);
      chk("drain_count", count, 15 - i);
      chk("drain_aempty", almost_empty, (15 - i) <= 2);
      chk("drain_rempty", rempty, i == 15);
    end
    cycle(0, 1, 8'h00);
    chk("unf_pulse", underflow, 1);
    chk("unf_rack", rack, 0);
    chk("unf_rdata_hold", rdata, 8'h0F);
    chk("unf_count", count, 0);
    cycle(0, 0, 8'h00);
    chk("unf_single", underflow, 0);

    // ---------------- Simultaneous on full ----------------
    for (int i = 0; i < 16; i++) cycle(1, 0, 8'(8'h10 + i));
    chk("full2_wfull", wfull, 1);
    cycle(1, 1, 8'h55);
    chk("sfull_rack", rack, 1);
    chk("sfull_ovf", overflow, 1);
    chk("sfull_wack", wack, 0);
    chk("sfull_count", count, 15);
    chk("sfull_wfull", wfull, 0);
    for (int i = 0; i < 15; i++) cycle(0, 1, 8'h00);
    chk("sfull_drained", rempty, 1);

    // ---------------- Simultaneous on empty ----------------
    cycle(1, 1, 8'h66);
    chk("sempty_wack", wack, 1);
    chk("sempty_unf", underflow, 1);
    chk("sempty_rack", rack, 0);
    chk("sempty_count", count, 1);
    cycle(0, 1, 8'h00);
    chk("sempty_rack2", rack, 1);
    chk("sempty_rdata", rdata, 8'h66);
    chk("sempty_count2", count, 0);

    // ---------------- Wrap-around streaming ----------------
    for (int i = 0; i < 5; i++) cycle(1, 0, 8'(8'h80 + i));
    chk("pre_count", count, 5);
    wtog = 0; rtog = 0;
    wmsb = dut.wptr[4]; rmsb = dut.rptr[4];
    for (int i = 0; i < 40; i++) begin
      cycle(1, 1, 8'(8'h85 + i));
      chk("stream_count", count, 5);
      if (dut.wptr[4] !== wmsb) wtog++;
      if (dut.rptr[4] !== rmsb) rtog++;
      wmsb = dut.wptr[4]; rmsb = dut.rptr[4];
    end
    chk("wptr_msb_toggles", wtog >= 2, 1);
    chk("rptr_msb_toggles", rtog >= 2, 1);

    // Reset mid-stream: entries discarded, requests ignored.
    @(negedge clk);
    rst_n = 1'b0; wen = 1'b1; ren = 1'b1; wdata = 8'hEE;
    model.delete();
    @(posedge clk); #1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_rempty", rempty, 1);
    chk("mid_rst_rack", rack, 0);
    @(negedge clk);
    rst_n = 1'b1; wen = 1'b0; ren = 1'b0;
    cycle(0, 0, 8'h00);
    chk("post_rst_count", count, 0);
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
